// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Fixed-latency word memory that answers single CPU read/write requests
//   over a shared tri-state data bus.
//
//   Parameters
//     LATENCY    cycles from request acceptance to the ready pulse (1..15)
//     ADDR_BITS  low address bits decoded; depth is 2**ADDR_BITS words (1..15)
//
//   Ports
//     clk        single clock, all state updates on the rising edge
//     reset      synchronous, active-high; clears state, err and all memory
//     readM      read request (accepted in IDLE when writeM is low)
//     writeM     write request (accepted in IDLE when readM is low)
//     address    word address; upper bits alias onto the decoded low bits
//     data       shared bus: CPU drives on write, this block drives read data
//                during DONE, high-Z otherwise
//     ready      one-cycle completion pulse (the DONE cycle)
//     err        sticky flag, set when readM and writeM are both high in IDLE
//     num_reads  completed-read counter   (only with MEM_RESPONDER_STATS_EN)
//     num_writes completed-write counter  (only with MEM_RESPONDER_STATS_EN)
//
//   Optional feature macro: MEM_RESPONDER_STATS_EN
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readM,
  input  logic        writeM,
  input  logic [15:0] address,
  inout  wire  [15:0] data,
  output logic        ready,
`ifdef MEM_RESPONDER_STATS_EN
  output logic        err,
  output logic [15:0] num_reads,
  output logic [15:0] num_writes
`else
  output logic        err
`endif
);

  localparam int unsigned DEPTH  = 1 << ADDR_BITS;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic                   mem_we;
  logic                   drive_rd;
  logic [15:0]            mem_q [DEPTH];

  // Address bits above ADDR_BITS simply alias; they are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[15:ADDR_BITS];

  // -------------------------------------------------------------------------
  // Next-state / datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (readM ^ writeM) begin
          op_wr_d = writeM;
          addr_d  = address[ADDR_BITS-1:0];
          wdata_d = data;
          cnt_d   = LAT_M1;
          if (LATENCY == 1) begin
            // Zero-wait case: commit happens on the accepting edge itself,
            // so the write uses the freshly captured address/data.
            state_d = DONE;
            mem_we  = writeM;
          end else begin
            state_d = BUSY;
          end
        end else if (readM && writeM) begin
          err_d = 1'b1;
        end
      end

      BUSY: begin
        // The counter reaches 0 on the same edge that enters DONE, so a
        // value of 1 here marks the final BUSY cycle.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = DONE;
          mem_we  = op_wr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Storage: cleared by reset, written on the edge entering DONE
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_BITS'(i)] <= '0;
      end
    end else if (mem_we) begin
      mem_q[addr_d] <= wdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign drive_rd = (state_q == DONE) && !op_wr_q;
  assign data     = drive_rd ? mem_q[addr_q] : 'z;
  assign ready    = (state_q == DONE);
  assign err      = err_q;

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] nrd_q, nwr_q;
  logic        done_entry;

  assign done_entry = (state_d == DONE) && (state_q != DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      nrd_q <= '0;
      nwr_q <= '0;
    end else if (done_entry) begin
      if (op_wr_d) begin
        nwr_q <= nwr_q + 16'd1;
      end else begin
        nrd_q <= nrd_q + 16'd1;
      end
    end
  end

  assign num_reads  = nrd_q;
  assign num_writes = nwr_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Two instances: u_dut0 (LATENCY=2, ADDR_BITS=8) and u_dut1 (LATENCY=1,
//   ADDR_BITS=4), each on its own bus. A transaction-level model predicts the
//   ready cycle, read data and err flag from acceptance times and a plain
//   memory array; directed requests add literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  rdM, wrM, rdy, erv;
  logic [15:0] addr  [2];
  logic [15:0] tb_wd [2];
  logic [1:0]  tb_den;
  wire  [15:0] bus0, bus1;

  assign bus0 = tb_den[0] ? tb_wd[0] : 'z;
  assign bus1 = tb_den[1] ? tb_wd[1] : 'z;

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] nrd [2];
  logic [15:0] nwr [2];
`endif

  mem_responder #(.LATENCY(2), .ADDR_BITS(8)) u_dut0 (
    .clk(clk), .reset(rst), .readM(rdM[0]), .writeM(wrM[0]),
    .address(addr[0]), .data(bus0), .ready(rdy[0]),
`ifdef MEM_RESPONDER_STATS_EN
    .err(erv[0]), .num_reads(nrd[0]), .num_writes(nwr[0])
`else
    .err(erv[0])
`endif
  );

  mem_responder #(.LATENCY(1), .ADDR_BITS(4)) u_dut1 (
    .clk(clk), .reset(rst), .readM(rdM[1]), .writeM(wrM[1]),
    .address(addr[1]), .data(bus1), .ready(rdy[1]),
`ifdef MEM_RESPONDER_STATS_EN
    .err(erv[1]), .num_reads(nrd[1]), .num_writes(nwr[1])
`else
    .err(erv[1])
`endif
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic [15:0] mask_of(input int d);
    return (d == 0) ? 16'h00FF : 16'h000F;
  endfunction

  function automatic logic [15:0] bus_of(input int d);
    return (d == 0) ? bus0 : bus1;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int d, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @cyc %0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Transaction-level model: acceptance edge -> completion edge bookkeeping
  // -------------------------------------------------------------------------
  int          cyc = 0;
  int          m_done [2] = '{-1, -1};   // edge index that starts the ready cycle
  int          m_ok   [2] = '{0, 0};     // first edge a new request may be taken
  bit          m_wr   [2];
  logic [15:0] m_a    [2];
  logic [15:0] m_wd   [2];
  bit          m_err  [2];
  logic [15:0] m_nrd  [2];
  logic [15:0] m_nwr  [2];
  logic [15:0] mmem   [2][256];
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 256; i++) mmem[d][i] = '0;
        m_err[d]  = 1'b0;
        m_done[d] = -1;
        m_ok[d]   = cyc + 1;
        m_nrd[d]  = '0;
        m_nwr[d]  = '0;
      end else begin
        if (cyc >= m_ok[d]) begin
          if (rdM[d] ^ wrM[d]) begin
            m_wr[d]   = wrM[d];
            m_a[d]    = addr[d] & mask_of(d);
            m_wd[d]   = bus_of(d);
            m_done[d] = cyc + lat_of(d) - 1;
            m_ok[d]   = m_done[d] + 2;
          end else if (rdM[d] && wrM[d]) begin
            m_err[d] = 1'b1;
          end
        end
        if (cyc == m_done[d]) begin
          if (m_wr[d]) begin
            mmem[d][m_a[d]] = m_wd[d];
            m_nwr[d]++;
          end else begin
            m_nrd[d]++;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        bit er;
        er = (cyc == m_done[d]);
        chk("ready", d, 16'(rdy[d]), 16'(er));
        chk("err", d, 16'(erv[d]), 16'(m_err[d]));
        if (er && !m_wr[d]) chk("rdata", d, bus_of(d), mmem[d][m_a[d]]);
`ifdef MEM_RESPONDER_STATS_EN
        chk("num_reads", d, nrd[d], m_nrd[d]);
        chk("num_writes", d, nwr[d], m_nwr[d]);
`endif
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic req(input int d, input bit rd, input bit wr,
                     input logic [15:0] a, input logic [15:0] wd,
                     output logic [15:0] rdata, output int lat);
    int c0;
    bit got;
    got   = 1'b0;
    rdata = '0;
    lat   = -1;
    @(negedge clk);
    rdM[d] = rd; wrM[d] = wr; addr[d] = a; tb_wd[d] = wd; tb_den[d] = wr;
    c0 = cyc;
    @(negedge clk);
    rdM[d] = 1'b0; wrM[d] = 1'b0; tb_den[d] = 1'b0; addr[d] = ~a;
    for (int i = 0; i < 20; i++) begin
      if (rdy[d]) begin
        got   = 1'b1;
        rdata = bus_of(d);
        lat   = cyc - c0;
        break;
      end
      @(negedge clk);
    end
    chk("ready_seen", d, 16'(got), 16'd1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  logic [15:0] rd;
  int          lat;

  initial begin
    rst = 1'b1; rdM = '0; wrM = '0; tb_den = '0;
    addr[0] = '0; addr[1] = '0; tb_wd[0] = '0; tb_wd[1] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", d, 16'(rdy[d]), 16'd0);
      chk("rst_err", d, 16'(erv[d]), 16'd0);
    end

    // Basic write then read, two-cycle latency.
    req(0, 1'b0, 1'b1, 16'h0005, 16'h1234, rd, lat);
    chk("wr_latency", 0, 16'(lat), 16'd2);
    req(0, 1'b1, 1'b0, 16'h0005, 16'h0000, rd, lat);
    chk("rd_latency", 0, 16'(lat), 16'd2);
    chk("rd_0005", 0, rd, 16'h1234);

    // Single-cycle latency read of cleared memory.
    req(1, 1'b1, 1'b0, 16'h0000, 16'h0000, rd, lat);
    chk("rd_latency1", 1, 16'(lat), 16'd1);
    chk("rd_0000", 1, rd, 16'h0000);

    // Aliasing of upper address bits.
    req(0, 1'b0, 1'b1, 16'h0107, 16'hAAAA, rd, lat);
    req(0, 1'b1, 1'b0, 16'h0007, 16'h0000, rd, lat);
    chk("rd_alias_0007", 0, rd, 16'hAAAA);

    req(1, 1'b0, 1'b1, 16'h00F2, 16'h5A5A, rd, lat);
    req(1, 1'b1, 1'b0, 16'h0002, 16'h0000, rd, lat);
    chk("rd_alias4_0002", 1, rd, 16'h5A5A);
    req(1, 1'b0, 1'b1, 16'h0003, 16'hC3C3, rd, lat);
    req(1, 1'b1, 1'b0, 16'h0013, 16'h0000, rd, lat);
    chk("rd_raw_0013", 1, rd, 16'hC3C3);
    req(1, 1'b1, 1'b0, 16'h0012, 16'h0000, rd, lat);
    chk("rd_alias4_0012", 1, rd, 16'h5A5A);

    // Held read request: re-accepted after each DONE + IDLE gap.
    req(0, 1'b0, 1'b1, 16'h0009, 16'h7777, rd, lat);
    @(negedge clk); rdM[0] = 1'b1; addr[0] = 16'h0009;
    repeat (8) @(negedge clk);
    rdM[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Both requests high in IDLE: sticky err, no completion.
    @(negedge clk); rdM[0] = 1'b1; wrM[0] = 1'b1; addr[0] = 16'h0001;
    @(negedge clk); rdM[0] = 1'b0; wrM[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_sticky", 0, 16'(erv[0]), 16'd1);
    chk("err_no_ready", 0, 16'(rdy[0]), 16'd0);
    do_reset();
    chk("err_cleared", 0, 16'(erv[0]), 16'd0);

    // Reset during BUSY aborts the pending write.
    req(0, 1'b0, 1'b1, 16'h0003, 16'h1111, rd, lat);
    do_reset();
    @(negedge clk);
    rdM[0] = 1'b0; wrM[0] = 1'b1; addr[0] = 16'h0003; tb_wd[0] = 16'hBEEF; tb_den[0] = 1'b1;
    @(negedge clk);
    wrM[0] = 1'b0; tb_den[0] = 1'b0; rst = 1'b1;
    chk("abort_busy_ready", 0, 16'(rdy[0]), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 0, 16'(rdy[0]), 16'd0);
    req(0, 1'b1, 1'b0, 16'h0003, 16'h0000, rd, lat);
    chk("rd_after_abort", 0, rd, 16'h0000);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
